// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the MemArray data port between the CPU and a DMA/loader master.
// Define DMEM_ARB_STARVE_EN to compile in the DMA anti-starvation counter.
module dmem_arbiter #(
   parameter int DBITS        = 16,
   parameter int ABITS        = 12,
   parameter int MAXLOCK      = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             CPU_REQ,
   input  logic             CPU_WE,
   input  logic [DBITS-1:0] CPU_ADDR,
   input  logic [DBITS-1:0] CPU_DIN,
   output logic             CPU_GNT,
   output logic             CPU_RVALID,
   output logic [DBITS-1:0] CPU_RDATA,
   input  logic             DMA_REQ,
   input  logic             DMA_WE,
   input  logic             DMA_LOCK,
   input  logic [DBITS-1:0] DMA_ADDR,
   input  logic [DBITS-1:0] DMA_DIN,
   output logic             DMA_GNT,
   output logic             DMA_RVALID,
   output logic [DBITS-1:0] DMA_RDATA,
   output logic [ABITS-1:0] MEM_ADDR,
   output logic [DBITS-1:0] MEM_DIN,
   output logic             MEM_WE,
   input  logic [DBITS-1:0] MEM_DOUT
);
   localparam int LW = $clog2(MAXLOCK + 1);
   localparam logic [DBITS-1:0] BAD_DATA = DBITS'(16'hDEAD);
   logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
   logic             lock_active_q, lock_active_d;
   logic             cpu_rvalid_q, cpu_rvalid_d;
   logic             dma_rvalid_q, dma_rvalid_d;
   logic             in_range_q, in_range_d;
   logic             starve_hit, lock_go, sel_we, sel_in_range, unused_addr_lsb;
   logic [DBITS-1:0] sel_addr;

`ifdef DMEM_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   assign starve_hit = starve_cnt_q == SW'(STARVE_LIMIT);
   // Only CPU wins against a waiting DMA reach the increment arm.
   always_comb
      starve_cnt_d = (DMA_GNT || !DMA_REQ) ? '0 :
                     starve_hit ? starve_cnt_q : starve_cnt_q + SW'(1);
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) starve_cnt_q <= '0;
      else starve_cnt_q <= starve_cnt_d;
`else
   localparam int unused_starve_limit = STARVE_LIMIT;
   assign starve_hit = 1'b0;
`endif

   always_comb begin
      DMA_GNT         = DMA_REQ && (lock_active_q || starve_hit || !CPU_REQ);
      CPU_GNT         = CPU_REQ && !DMA_GNT;
      sel_addr        = DMA_GNT ? DMA_ADDR : CPU_ADDR;
      MEM_DIN         = DMA_GNT ? DMA_DIN : CPU_DIN;
      sel_we          = DMA_GNT ? DMA_WE : CPU_WE;
      sel_in_range    = sel_addr[DBITS-1:ABITS+1] == '0;
      MEM_ADDR        = sel_addr[ABITS:1];
      MEM_WE          = (CPU_GNT || DMA_GNT) && sel_we && sel_in_range;
      unused_addr_lsb = sel_addr[0];
      // The lock expires on the MAXLOCK-th grant so the CPU gets one arbitration.
      lock_go         = DMA_GNT && DMA_LOCK;
      lock_cnt_d      = !lock_go ? '0 :
                        (lock_cnt_q == LW'(MAXLOCK)) ? lock_cnt_q : lock_cnt_q + LW'(1);
      lock_active_d   = lock_go && (int'(lock_cnt_q) + 1 < MAXLOCK);
      cpu_rvalid_d    = CPU_GNT && !CPU_WE;
      dma_rvalid_d    = DMA_GNT && !DMA_WE;
      in_range_d      = sel_in_range;
   end

   assign CPU_RVALID = cpu_rvalid_q;
   assign DMA_RVALID = dma_rvalid_q;
   assign CPU_RDATA  = !cpu_rvalid_q ? '0 : in_range_q ? MEM_DOUT : BAD_DATA;
   assign DMA_RDATA  = !dma_rvalid_q ? '0 : in_range_q ? MEM_DOUT : BAD_DATA;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         lock_cnt_q    <= '0;
         lock_active_q <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         dma_rvalid_q  <= 1'b0;
         in_range_q    <= 1'b0;
      end else begin
         lock_cnt_q    <= lock_cnt_d;
         lock_active_q <= lock_active_d;
         cpu_rvalid_q  <= cpu_rvalid_d;
         dma_rvalid_q  <= dma_rvalid_d;
         in_range_q    <= in_range_d;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a rule-level arbiter/memory model checked every cycle.
// Honours DMEM_ARB_STARVE_EN the same way as the design.
module tb_dmem_arbiter;
   localparam int STARVE_LIMIT = 3;
   localparam int MAXLOCK      = 4;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif
   logic        CLK = 1'b0, RESET_N = 1'b1;
   logic        CPU_REQ = 1'b0, CPU_WE = 1'b0, DMA_REQ = 1'b0, DMA_WE = 1'b0, DMA_LOCK = 1'b0;
   logic [15:0] CPU_ADDR = '0, CPU_DIN = '0, DMA_ADDR = '0, DMA_DIN = '0;
   logic        CPU_GNT, CPU_RVALID, DMA_GNT, DMA_RVALID, MEM_WE;
   logic [15:0] CPU_RDATA, DMA_RDATA, MEM_DIN;
   logic [15:0] MEM_DOUT = '0;
   logic [11:0] MEM_ADDR;
   logic [15:0] mem  [0:4095];
   logic [15:0] mmem [0:4095];
   int          errors = 0, checks = 0;
   int          m_starve = 0, m_run = 0;
   logic        m_lock = 1'b0, p_valid = 1'b0, p_dma = 1'b0;
   logic [15:0] p_data = '0;
   logic        eg_c, eg_d, e_we, e_inr;
   logic [15:0] e_addr, e_din;
   logic [7:0]  pat;

   dmem_arbiter dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
      .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
      .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_LOCK(DMA_LOCK), .DMA_ADDR(DMA_ADDR),
      .DMA_DIN(DMA_DIN), .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_RDATA(DMA_RDATA),
      .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WE(MEM_WE), .MEM_DOUT(MEM_DOUT)
   );

   always #5 CLK = ~CLK;

   // MemArray stand-in: synchronous write, read data one cycle after the address.
   always @(posedge CLK) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
      MEM_DOUT <= mem[MEM_ADDR];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mid-cycle, grant from the priority rules, read data from the model's own memory.
   initial forever begin
      @(negedge CLK);
      if (!RESET_N) begin
         m_starve = 0; m_run = 0; m_lock = 1'b0; p_valid = 1'b0;
      end
      chk("cpu_rvalid", CPU_RVALID, p_valid && !p_dma);
      chk("cpu_rdata", CPU_RDATA, (p_valid && !p_dma) ? p_data : 16'h0);
      chk("dma_rvalid", DMA_RVALID, p_valid && p_dma);
      chk("dma_rdata", DMA_RDATA, (p_valid && p_dma) ? p_data : 16'h0);
      if (DMA_REQ && m_lock) eg_d = 1'b1;
      else if (DMA_REQ && STARVE && m_starve == STARVE_LIMIT) eg_d = 1'b1;
      else if (CPU_REQ) eg_d = 1'b0;
      else eg_d = DMA_REQ;
      eg_c   = CPU_REQ && !eg_d;
      e_addr = eg_d ? DMA_ADDR : CPU_ADDR;
      e_din  = eg_d ? DMA_DIN : CPU_DIN;
      e_we   = eg_d ? DMA_WE : CPU_WE;
      e_inr  = e_addr < 16'h2000;
      chk("cpu_gnt", CPU_GNT, eg_c);
      chk("dma_gnt", DMA_GNT, eg_d);
      chk("mem_we", MEM_WE, (eg_c || eg_d) && e_we && e_inr);
      chk("mem_addr", MEM_ADDR, e_addr[12:1]);
      chk("mem_din", MEM_DIN, e_din);
      if (RESET_N) begin
         p_valid = (eg_c || eg_d) && !e_we;
         p_dma   = eg_d;
         p_data  = e_inr ? mmem[e_addr[12:1]] : 16'hDEAD;
         if ((eg_c || eg_d) && e_we && e_inr) mmem[e_addr[12:1]] = e_din;
         if (eg_d || !DMA_REQ) m_starve = 0;
         else if (m_starve < STARVE_LIMIT) m_starve++;
         if (eg_d && DMA_LOCK) begin
            if (m_run < MAXLOCK) m_run++;
            m_lock = m_run < MAXLOCK;
         end else begin
            m_run = 0; m_lock = 1'b0;
         end
      end
   end

   task automatic drive(input logic cr, cw, input logic [15:0] ca, cd,
                        input logic dr, dw, dl, input logic [15:0] da, dd);
      CPU_REQ = cr; CPU_WE = cw; CPU_ADDR = ca; CPU_DIN = cd;
      DMA_REQ = dr; DMA_WE = dw; DMA_LOCK = dl; DMA_ADDR = da; DMA_DIN = dd;
   endtask

   task automatic step(input logic cr, cw, input logic [15:0] ca, cd,
                       input logic dr, dw, dl, input logic [15:0] da, dd);
      @(posedge CLK);
      #2 drive(cr, cw, ca, cd, dr, dw, dl, da, dd);
      @(negedge CLK);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i] = '0; mmem[i] = '0;
      end
      mem[1] = 16'hAAAA; mmem[1] = 16'hAAAA;
      mem[2] = 16'h5555; mmem[2] = 16'h5555;
      #1 RESET_N = 1'b0;
      repeat (3) @(posedge CLK);
      #2 RESET_N = 1'b1;
      idle();
      chk("rst_cpu_rvalid", CPU_RVALID, 1'b0);
      chk("rst_dma_rvalid", DMA_RVALID, 1'b0);
      chk("rst_dma_rdata", DMA_RDATA, 16'h0);
      step(1, 1, 16'h0100, 16'h1234, 0, 0, 0, 16'h0, 16'h0);
      chk("wr_gnt", CPU_GNT, 1'b1);
      chk("wr_we", MEM_WE, 1'b1);
      chk("wr_addr", MEM_ADDR, 12'h080);
      step(1, 0, 16'h0100, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      chk("rd_we", MEM_WE, 1'b0);
      idle();
      chk("rd_cpu_rvalid", CPU_RVALID, 1'b1);
      chk("rd_cpu_rdata", CPU_RDATA, 16'h1234);
      chk("rd_dma_rvalid", DMA_RVALID, 1'b0);
      step(0, 0, 16'h0, 16'h0, 1, 1, 0, 16'hFFF8, 16'hBEEF);
      chk("oor_gnt", DMA_GNT, 1'b1);
      chk("oor_we", MEM_WE, 1'b0);
      step(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'hFFF8, 16'h0);
      idle();
      chk("oor_rvalid", DMA_RVALID, 1'b1);
      chk("oor_rdata", DMA_RDATA, 16'hDEAD);
      chk("oor_cpu_rvalid", CPU_RVALID, 1'b0);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 16'h0002, 16'h0, 1, 0, 0, 16'h0004, 16'h0);
         pat = {pat[6:0], DMA_GNT};
      end
      chk("starve_pat", pat, STARVE ? 8'b0001_0001 : 8'b0000_0000);
      idle();
      step(0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0004, 16'h0);
      chk("lock_first", DMA_GNT, 1'b1);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 16'h0002, 16'h0, 1, 0, 1, 16'h0004, 16'h0);
         pat = {pat[6:0], DMA_GNT};
      end
      chk("lock_pat", pat, STARVE ? 8'b1110_0011 : 8'b1110_0000);
      step(1, 0, 16'h0002, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      chk("drop_cpu", CPU_GNT, 1'b1);
      step(1, 0, 16'h0002, 16'h0, 1, 0, 1, 16'h0004, 16'h0);
      chk("unlock_cpu", CPU_GNT, 1'b1);
      chk("unlock_dma", DMA_GNT, 1'b0);
      idle();
      step(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0040, 16'h0);
      chk("mid_gnt", DMA_GNT, 1'b1);
      @(posedge CLK);
      #2 RESET_N = 1'b0;
      drive(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      @(negedge CLK);
      #1 chk("mid_rst_rvalid", DMA_RVALID, 1'b0);
      @(posedge CLK);
      #2 RESET_N = 1'b1;
      idle();
      chk("post_rst_dma_rvalid", DMA_RVALID, 1'b0);
      chk("post_rst_cpu_rvalid", CPU_RVALID, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 16'h0002, 16'h0, 0, 0, 0, 16'h0, 16'h0);
         if (i > 0) chk("il_dma_rdata", DMA_RDATA, 16'h5555);
         step(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0004, 16'h0);
         chk("il_cpu_rdata", CPU_RDATA, 16'hAAAA);
         chk("il_dma_rvalid_low", DMA_RVALID, 1'b0);
      end
      idle();
      chk("il_last_dma_rdata", DMA_RDATA, 16'h5555);
      chk("il_last_cpu_rvalid", CPU_RVALID, 1'b0);
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
